mc_wb_periph_slice: RTL and testbench

Registered bridge on the peripheral wishbone port of the memory-controller bus. It sits between the bus block's per-slave cyc/ack peripheral port and the actual peripheral slaves. It adds one register stage in each direction to cut timing paths, and it returns correctly formatted ack and rdata lanes. Optionally, it terminates hung accesses with a timeout error response.

---
 rtl/mc_pkg.sv | 14 +
 rtl/mc_wb_periph_slice_if.sv | 25 ++
 rtl/mc_prio_enc.sv | 29 ++
 rtl/mc_wb_periph_slice.sv | 157 +++++++++++++++
 tb/tb_mc_wb_periph_slice.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the memory-controller peripheral wishbone slice:
// FSM encoding, peripheral address width and the default timeout read data.
package mc_pkg;

    localparam int          PERIPH_AW        = 22;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hdeadbeef;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mc_wb_periph_slice_if.sv
// Peripheral wishbone port bundle: shared request fields plus per-lane cyc/ack/rdata.
// The bridge is the slave on the bus-facing side and the master on the slave-facing side.
interface mc_wb_periph_slice_if
    import mc_pkg::*;
#(
    parameter int WB_N = 2
);
    logic [PERIPH_AW-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           wmsk;
    logic                 we;
    logic [WB_N-1:0]      cyc;
    logic [WB_N-1:0]      ack;
    logic [32*WB_N-1:0]   rdata;

    modport master (
        output addr, wdata, wmsk, we, cyc,
        input  ack, rdata
    );

    modport slave (
        input  addr, wdata, wmsk, we, cyc,
        output ack, rdata
    );
endinterface

// File: rtl/mc_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index and an any-request flag.
module mc_prio_enc #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);
    // seen[i] is set when some lane below i is requesting
    logic [N:0] seen;

    assign seen[0] = 1'b0;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign onehot[gi]   = req[gi] & ~seen[gi];
        assign seen[gi + 1] = seen[gi] | req[gi];
    end

    assign any = seen[N];

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end
endmodule

// File: rtl/mc_wb_periph_slice.sv
// Registered bridge on the peripheral wishbone port: one flop stage each way, per-lane ack/rdata.
// Define MC_WB_PERIPH_TIMEOUT_EN to terminate hung accesses with ERR_DATA and a sticky error.
module mc_wb_periph_slice
    import mc_pkg::*;
#(
    parameter int          WB_N      = 2,
    parameter int          TO_CYCLES = 255,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    mc_wb_periph_slice_if.slave  up,
    mc_wb_periph_slice_if.master dn,
    output logic                 err_flag,
    output logic [PERIPH_AW-1:0] err_addr,
    input  logic                 err_clr
);
    localparam int IW = (WB_N > 1) ? $clog2(WB_N) : 1;

    state_e state_reg, state_next;

    logic [WB_N-1:0]      req_onehot;
    logic [IW-1:0]        req_idx;
    logic                 req_any;
    logic                 load_req;
    logic                 ack_hit;
    logic                 to_hit;
    logic                 resp_load;
    logic [31:0]          resp_data;

    logic [PERIPH_AW-1:0] dn_addr_reg;
    logic [31:0]          dn_wdata_reg;
    logic [3:0]           dn_wmsk_reg;
    logic                 dn_we_reg;
    logic [WB_N-1:0]      dn_cyc_reg;
    logic [WB_N-1:0]      sel_reg;
    logic [IW-1:0]        idx_reg;
    logic [WB_N-1:0]      up_ack_reg;
    logic [32*WB_N-1:0]   up_rdata_reg;
    logic [32*WB_N-1:0]   up_rdata_next;

    mc_prio_enc #(.N(WB_N), .IW(IW)) u_prio_enc (
        .req    (up.cyc),
        .onehot (req_onehot),
        .idx    (req_idx),
        .any    (req_any)
    );

    // Only the selected lane's ack counts, and only while the request is outstanding
    assign ack_hit   = (state_reg == ST_REQ) && |(dn.ack & sel_reg);
    assign resp_load = ack_hit | to_hit;
    assign resp_data = ack_hit ? dn.rdata[idx_reg*32 +: 32] : ERR_DATA;

    for (genvar gi = 0; gi < WB_N; gi++) begin : g_rdata
        assign up_rdata_next[gi*32 +: 32] = sel_reg[gi] ? resp_data : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load_req   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_any) begin
                    load_req   = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ:  if (resp_load) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dn_addr_reg  <= '0;
            dn_wdata_reg <= '0;
            dn_wmsk_reg  <= '0;
            dn_we_reg    <= 1'b0;
            dn_cyc_reg   <= '0;
            sel_reg      <= '0;
            idx_reg      <= '0;
            up_ack_reg   <= '0;
            up_rdata_reg <= '0;
        end else begin
            if (load_req) begin
                dn_addr_reg  <= up.addr;
                dn_wdata_reg <= up.wdata;
                dn_wmsk_reg  <= up.wmsk;
                dn_we_reg    <= up.we;
                dn_cyc_reg   <= req_onehot;
                sel_reg      <= req_onehot;
                idx_reg      <= req_idx;
            end
            if (resp_load) begin
                dn_cyc_reg   <= '0;
                up_ack_reg   <= sel_reg;
                up_rdata_reg <= up_rdata_next;
            end else begin
                up_ack_reg   <= '0;
                up_rdata_reg <= '0;
            end
        end
    end

`ifdef MC_WB_PERIPH_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

    logic [15:0]          cnt_reg;
    logic                 err_flag_reg;
    logic [PERIPH_AW-1:0] err_addr_reg;

    // An ack in the final cycle beats the timeout
    assign to_hit = (state_reg == ST_REQ) && !ack_hit && (cnt_reg == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg      <= '0;
            err_flag_reg <= 1'b0;
            err_addr_reg <= '0;
        end else begin
            if (load_req)                cnt_reg <= '0;
            else if (state_reg == ST_REQ) cnt_reg <= cnt_reg + 16'd1;

            if (err_clr) begin
                err_flag_reg <= 1'b0;
            end else if (to_hit && !err_flag_reg) begin
                err_flag_reg <= 1'b1;
                err_addr_reg <= dn_addr_reg;
            end
        end
    end

    assign err_flag = err_flag_reg;
    assign err_addr = err_addr_reg;
`else
    logic unused_cfg;

    assign to_hit     = 1'b0;
    assign err_flag   = 1'b0;
    assign err_addr   = '0;
    assign unused_cfg = &{1'b0, err_clr, TO_CYCLES[0]};
`endif

    assign dn.addr  = dn_addr_reg;
    assign dn.wdata = dn_wdata_reg;
    assign dn.wmsk  = dn_wmsk_reg;
    assign dn.we    = dn_we_reg;
    assign dn.cyc   = dn_cyc_reg;
    assign up.ack   = up_ack_reg;
    assign up.rdata = up_rdata_reg;
endmodule

// File: tb/tb_mc_wb_periph_slice.sv
// Directed bench for mc_wb_periph_slice (WB_N=2, TO_CYCLES=8); timeout cases run when
// MC_WB_PERIPH_TIMEOUT_EN is defined, otherwise the indefinite-wait behaviour is checked.
module tb_mc_wb_periph_slice;
    import mc_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 err_flag;
    logic [PERIPH_AW-1:0] err_addr;
    logic                 err_clr;

    int checks   = 0;
    int failures = 0;

    mc_wb_periph_slice_if #(.WB_N(2)) up_bus ();
    mc_wb_periph_slice_if #(.WB_N(2)) dn_bus ();

    mc_wb_periph_slice #(
        .WB_N      (2),
        .TO_CYCLES (8),
        .ERR_DATA  (32'hdeadbeef)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up_bus),
        .dn       (dn_bus),
        .err_flag (err_flag),
        .err_addr (err_addr),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [1:0] cyc, input logic [21:0] addr, input logic we,
                             input logic [31:0] wdata, input logic [3:0] wmsk);
        up_bus.cyc   = cyc;
        up_bus.addr  = addr;
        up_bus.we    = we;
        up_bus.wdata = wdata;
        up_bus.wmsk  = wmsk;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] seen_ack;
        rst = 1'b0;
        err_clr = 1'b0;
        start_req(2'b00, 22'h0, 1'b0, 32'h0, 4'h0);
        dn_bus.ack   = 2'b00;
        dn_bus.rdata = 64'h0;
        #12;
        check("rst_dn_cyc", 64'(dn_bus.cyc), 64'h0);
        check("rst_dn_addr", 64'(dn_bus.addr), 64'h0);
        check("rst_up_ack", 64'(up_bus.ack), 64'h0);
        check("rst_up_rdata", up_bus.rdata, 64'h0);
        check("rst_err", {41'h0, err_flag, err_addr}, 64'h0);
        tick();
        rst = 1'b1;
        tick();

        // Read on lane 1, slave acks two cycles after dn_cyc
        $display("txn read lane1 addr=00123");
        start_req(2'b10, 22'h00123, 1'b0, 32'h0, 4'h0);
        tick();
        check("rd_dn_cyc", 64'(dn_bus.cyc), 64'h2);
        check("rd_dn_addr", 64'(dn_bus.addr), 64'h123);
        check("rd_no_early_ack", 64'(up_bus.ack), 64'h0);
        tick();
        tick();
        check("rd_dn_cyc_held", 64'(dn_bus.cyc), 64'h2);
        dn_bus.ack   = 2'b10;
        dn_bus.rdata = {32'hcafef00d, 32'h12345678};
        tick();
        dn_bus.ack   = 2'b00;
        dn_bus.rdata = 64'h0;
        check("rd_up_ack", 64'(up_bus.ack), 64'h2);
        check("rd_up_rdata", up_bus.rdata, {32'hcafef00d, 32'h0});
        check("rd_dn_cyc_drop", 64'(dn_bus.cyc), 64'h0);
        tick();
        up_bus.cyc = 2'b00;
        check("rd_ack_pulse", 64'(up_bus.ack), 64'h0);
        check("rd_rdata_clr", up_bus.rdata, 64'h0);
        tick();

        // Write on lane 0; upstream fields change mid-access to prove dn_* hold
        $display("txn write lane0 addr=2abcd");
        start_req(2'b01, 22'h2abcd, 1'b1, 32'h11223344, 4'b0101);
        tick();
        check("wr_dn_fields", {dn_bus.wdata, 26'h0, dn_bus.wmsk, dn_bus.we, dn_bus.cyc[0]},
              {32'h11223344, 26'h0, 4'b0101, 1'b1, 1'b1});
        up_bus.wdata = 32'h99999999;
        up_bus.wmsk  = 4'b1111;
        up_bus.we    = 1'b0;
        up_bus.addr  = 22'h0;
        tick();
        check("wr_dn_stable", {dn_bus.wdata, 4'h0, dn_bus.wmsk, 2'b0, dn_bus.addr},
              {32'h11223344, 4'h0, 4'b0101, 2'b0, 22'h2abcd});
        check("wr_we_stable", 64'(dn_bus.we), 64'h1);
        dn_bus.ack   = 2'b01;
        dn_bus.rdata = {32'hffffffff, 32'h0};
        tick();
        dn_bus.ack   = 2'b00;
        dn_bus.rdata = 64'h0;
        check("wr_up_ack", 64'(up_bus.ack), 64'h1);
        check("wr_up_rdata", up_bus.rdata, 64'h0);
        tick();
        up_bus.cyc = 2'b00;
        check("wr_ack_pulse", 64'(up_bus.ack), 64'h0);
        tick();

        // Same-cycle ack gives the minimum 3-cycle latency
        $display("txn read lane0 same-cycle ack");
        start_req(2'b01, 22'h00040, 1'b0, 32'h0, 4'h0);
        tick();
        dn_bus.ack   = 2'b01;
        dn_bus.rdata = {32'h0, 32'ha5a50001};
        tick();
        dn_bus.ack   = 2'b00;
        dn_bus.rdata = 64'h0;
        check("min_lat_ack", 64'(up_bus.ack), 64'h1);
        check("min_lat_rdata", up_bus.rdata, {32'h0, 32'ha5a50001});
        tick();
        up_bus.cyc = 2'b00;
        tick();

        // Multi-hot request: lane 0 first, lane 1 as a fresh access; wrong-lane ack ignored
        $display("txn multi-hot 11");
        start_req(2'b11, 22'h00077, 1'b0, 32'h0, 4'h0);
        tick();
        check("mh_lane0_first", 64'(dn_bus.cyc), 64'h1);
        dn_bus.ack   = 2'b01;
        dn_bus.rdata = {32'h0, 32'h00000abc};
        tick();
        dn_bus.ack   = 2'b00;
        check("mh_ack0", 64'(up_bus.ack), 64'h1);
        tick();
        up_bus.cyc = 2'b10;
        check("mh_idle_gap", {62'h0, dn_bus.cyc | up_bus.ack}, 64'h0);
        tick();
        check("mh_lane1_fresh", 64'(dn_bus.cyc), 64'h2);
        dn_bus.ack   = 2'b01;
        tick();
        dn_bus.ack   = 2'b00;
        check("mh_wrong_lane_ack", {62'h0, up_bus.ack}, 64'h0);
        check("mh_still_req", 64'(dn_bus.cyc), 64'h2);
        dn_bus.ack   = 2'b10;
        dn_bus.rdata = {32'h0000def0, 32'h0};
        tick();
        dn_bus.ack   = 2'b00;
        dn_bus.rdata = 64'h0;
        check("mh_ack1", 64'(up_bus.ack), 64'h2);
        check("mh_rdata1", up_bus.rdata, {32'h0000def0, 32'h0});
        tick();
        up_bus.cyc = 2'b00;
        tick();

`ifdef MC_WB_PERIPH_TIMEOUT_EN
        // Lane 0 never acks: eight REQ cycles then error response
        $display("txn timeout lane0 addr=3f00f");
        start_req(2'b01, 22'h3f00f, 1'b0, 32'h0, 4'h0);
        tick();
        repeat (7) tick();
        check("to_cyc_last", 64'(dn_bus.cyc), 64'h1);
        check("to_no_ack_yet", 64'(up_bus.ack), 64'h0);
        tick();
        check("to_cyc_drop", 64'(dn_bus.cyc), 64'h0);
        check("to_up_ack", 64'(up_bus.ack), 64'h1);
        check("to_rdata", up_bus.rdata, {32'h0, 32'hdeadbeef});
        check("to_err", {41'h0, err_flag, err_addr}, {41'h0, 1'b1, 22'h3f00f});
        tick();
        up_bus.cyc = 2'b00;
        tick();

        $display("txn timeout lane1 addr=01111 (second)");
        start_req(2'b10, 22'h01111, 1'b0, 32'h0, 4'h0);
        tick();
        repeat (8) tick();
        check("to2_rdata", up_bus.rdata, {32'hdeadbeef, 32'h0});
        check("to2_err_keep", {41'h0, err_flag, err_addr}, {41'h0, 1'b1, 22'h3f00f});
        tick();
        up_bus.cyc = 2'b00;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_err_clr", {41'h0, err_flag, err_addr}, {41'h0, 1'b0, 22'h3f00f});

        $display("txn ack on final timeout cycle");
        start_req(2'b01, 22'h00007, 1'b0, 32'h0, 4'h0);
        tick();
        repeat (7) tick();
        dn_bus.ack   = 2'b01;
        dn_bus.rdata = {32'h0, 32'h0badf00d};
        tick();
        dn_bus.ack   = 2'b00;
        dn_bus.rdata = 64'h0;
        check("late_ack_data", up_bus.rdata, {32'h0, 32'h0badf00d});
        check("late_ack_noerr", 64'(err_flag), 64'h0);
        tick();
        up_bus.cyc = 2'b00;
        tick();

        $display("txn timeout with simultaneous err_clr");
        start_req(2'b01, 22'h00222, 1'b0, 32'h0, 4'h0);
        tick();
        repeat (7) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_prio_ack", 64'(up_bus.ack), 64'h1);
        check("clr_prio_err", {41'h0, err_flag, err_addr}, {41'h0, 1'b0, 22'h3f00f});
        tick();
        up_bus.cyc = 2'b00;
        tick();
`else
        $display("txn lane0 long wait, no timeout");
        start_req(2'b01, 22'h00222, 1'b0, 32'h0, 4'h0);
        tick();
        seen_ack = 2'b00;
        repeat (20) begin
            tick();
            seen_ack |= up_bus.ack;
        end
        check("nto_still_req", {62'h0, dn_bus.cyc}, 64'h1);
        check("nto_no_ack", {62'h0, seen_ack}, 64'h0);
        check("nto_no_err", {41'h0, err_flag, err_addr}, 64'h0);
        dn_bus.ack   = 2'b01;
        dn_bus.rdata = {32'h0, 32'h00005a5a};
        tick();
        dn_bus.ack   = 2'b00;
        dn_bus.rdata = 64'h0;
        check("nto_ack", 64'(up_bus.ack), 64'h1);
        tick();
        up_bus.cyc = 2'b00;
        tick();
`endif

        // Reset mid-access drops dn_cyc without a clock edge and loses the response
        $display("txn async reset in REQ");
        start_req(2'b01, 22'h00055, 1'b0, 32'h0, 4'h0);
        tick();
        check("ar_in_req", 64'(dn_bus.cyc), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_cyc_async", 64'(dn_bus.cyc), 64'h0);
        check("ar_ack_async", 64'(up_bus.ack), 64'h0);
        dn_bus.ack = 2'b01;
        up_bus.cyc = 2'b00;
        tick();
        tick();
        dn_bus.ack = 2'b00;
        rst = 1'b1;
        seen_ack = 2'b00;
        repeat (4) begin
            tick();
            seen_ack |= up_bus.ack;
        end
        check("ar_no_ack_after", {62'h0, seen_ack}, 64'h0);
        check("ar_idle_cyc", 64'(dn_bus.cyc), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
